// File: rtl/digit_subseq_maxer.sv
// rtl/digit_subseq_maxer.sv - streaming largest length-k digit subsequence per line, with running total
module digit_subseq_maxer #(
  parameter int MAX_K   = 12,
  parameter int DIGIT_W = 4,
  parameter int LEN_W   = 8,
  parameter int RES_W   = 64,
  parameter int SUM_W   = 64
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [$clog2(MAX_K):0]     k,
  input  logic [LEN_W-1:0]           line_len,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DIGIT_W-1:0]         in_digit,
  input  logic                       in_last,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [RES_W-1:0]           res_value,
  output logic                       res_err,
  input  logic                       clear_total,
  output logic [SUM_W-1:0]           total
);

  localparam int KW  = $clog2(MAX_K) + 1;
  localparam int SPW = $clog2(MAX_K + 1);

  typedef enum logic [1:0] {ACCUM, CONVERT, OUTPUT} state_t;

  state_t               state;
  logic [DIGIT_W-1:0]   data [MAX_K];
  logic [SPW-1:0]       sp;
  logic [SPW-1:0]       cnt;
  logic [LEN_W-1:0]     idx;
  logic [LEN_W-1:0]     len_q;
  logic [KW-1:0]        k_q;
  logic                 err_q;
  logic [RES_W-1:0]     acc;

  logic [KW-1:0]        k_eff;
  logic [LEN_W-1:0]     len_eff;
  logic [DIGIT_W-1:0]   d;
  logic                 k_bad;
  logic                 is_end;
  logic                 beat_last;
  logic                 beat_err;
  logic                 do_write;
  logic [SPW-1:0]       p_idx;
  logic                 handshake;

  assign in_ready  = (state == ACCUM);
  assign handshake = (state == OUTPUT) && res_valid && res_ready;

  // First beat of a line uses the live k/line_len; later beats use the sampled copies.
  always_comb begin
    int rem;
    int lo;
    int p;
    k_eff     = (idx == '0) ? k : k_q;
    len_eff   = (idx == '0) ? line_len : len_q;
    k_bad     = (k_eff == '0) || (int'(k_eff) > MAX_K);
    d         = (int'(in_digit) <= 9) ? in_digit : '0;
    is_end    = (idx == len_eff - LEN_W'(1));
    beat_last = in_last || is_end;
    beat_err  = (int'(in_digit) > 9) || (in_last != is_end) || k_bad ||
                ((idx == '0) && (int'(len_eff) < int'(k_eff)));
    rem = int'(len_eff) - int'(idx);
    lo  = int'(k_eff) - rem;
    if (lo < 0) lo = 0;
    // A short line can leave too few slots to reach k; keep what fits.
    if (lo > int'(sp)) lo = int'(sp);
    p = int'(sp);
    for (int i = MAX_K - 1; i >= 0; i--) begin
      if (i < int'(sp) && i >= lo && p == i + 1 && int'(data[i]) < int'(d)) p = i;
    end
    do_write = !k_bad && (p < int'(k_eff));
    p_idx    = SPW'(p);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ACCUM;
      sp        <= '0;
      cnt       <= '0;
      idx       <= '0;
      len_q     <= '0;
      k_q       <= '0;
      err_q     <= 1'b0;
      acc       <= '0;
      res_valid <= 1'b0;
      res_value <= '0;
      res_err   <= 1'b0;
      total     <= '0;
      for (int i = 0; i < MAX_K; i++) data[i] <= '0;
    end else begin
      if (handshake) total <= clear_total ? SUM_W'(res_value) : total + SUM_W'(res_value);
      else if (clear_total) total <= '0;

      case (state)
        ACCUM: begin
          if (in_valid) begin
            if (idx == '0) begin
              k_q   <= k;
              len_q <= line_len;
            end
            if (do_write) begin
              data[p_idx] <= d;
              sp          <= p_idx + SPW'(1);
            end
            err_q <= err_q | beat_err;
            idx   <= idx + LEN_W'(1);
            if (beat_last) begin
              cnt   <= '0;
              state <= CONVERT;
            end
          end
        end
        CONVERT: begin
          if (cnt < sp) begin
            acc <= acc * RES_W'(10) + RES_W'(data[cnt]);
            cnt <= cnt + SPW'(1);
          end else begin
            res_value <= acc;
            res_err   <= err_q;
            res_valid <= 1'b1;
            state     <= OUTPUT;
          end
        end
        OUTPUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            sp        <= '0;
            idx       <= '0;
            acc       <= '0;
            cnt       <= '0;
            err_q     <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_subseq_maxer.sv
// tb/tb_digit_subseq_maxer.sv - directed vectors for digit_subseq_maxer
module tb_digit_subseq_maxer;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  k;
  logic [7:0]  line_len;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_digit;
  logic        in_last;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] res_value;
  logic        res_err;
  logic        clear_total;
  logic [63:0] total;

  int checks = 0;
  int errors = 0;
  logic [63:0] model_total = 64'd0;

  always #5 clock = ~clock;

  digit_subseq_maxer dut (
    .clock(clock), .reset(reset), .k(k), .line_len(line_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_digit(in_digit), .in_last(in_last),
    .res_valid(res_valid), .res_ready(res_ready), .res_value(res_value), .res_err(res_err),
    .clear_total(clear_total), .total(total)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run_line(input string s, input int kk, input int ll, input logic [63:0] ev,
                          input logic ee, input int stall, input bit clr);
    int waited;
    @(negedge clock);
    check("in_ready_idle", in_ready, 1);
    for (int i = 0; i < s.len(); i++) begin
      in_valid = 1'b1;
      in_digit = 4'(s[i] - 8'd48);
      in_last  = (i == s.len() - 1);
      k        = 5'(kk);
      line_len = 8'(ll);
      @(negedge clock);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    waited = 0;
    while (!res_valid && waited < 40) begin
      @(negedge clock);
      waited++;
    end
    check("res_valid_rise", res_valid, 1);
    check("res_value", res_value, ev);
    check("res_err", res_err, ee);
    for (int c = 0; c < stall; c++) begin
      @(negedge clock);
      check("stall_value", res_value, ev);
      check("stall_in_ready", in_ready, 0);
      check("stall_total", total, model_total);
    end
    res_ready   = 1'b1;
    clear_total = clr;
    @(negedge clock);
    res_ready   = 1'b0;
    clear_total = 1'b0;
    model_total = clr ? ev : model_total + ev;
    check("total_after", total, model_total);
    check("res_valid_drop", res_valid, 0);
  endtask

  initial begin
    reset = 1'b1; k = 5'd2; line_len = 8'd15; in_valid = 1'b0; in_digit = 4'd0;
    in_last = 1'b0; res_ready = 1'b0; clear_total = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_value", res_value, 0);
    check("rst_res_err", res_err, 0);
    check("rst_total", total, 0);

    run_line("987654321111111", 2, 15, 64'd98, 1'b0, 0, 1'b0);
    run_line("811111111111119", 2, 15, 64'd89, 1'b0, 0, 1'b0);
    run_line("234234234234278", 2, 15, 64'd78, 1'b0, 0, 1'b0);
    run_line("818181911112111", 2, 15, 64'd92, 1'b0, 0, 1'b0);
    check("total_k2", total, 64'd357);

    @(negedge clock);
    clear_total = 1'b1;
    @(negedge clock);
    clear_total = 1'b0;
    model_total = 64'd0;
    check("clear_alone", total, 0);

    run_line("987654321111111", 12, 15, 64'd987654321111, 1'b0, 10, 1'b0);
    run_line("811111111111119", 12, 15, 64'd811111111119, 1'b0, 0, 1'b0);
    run_line("234234234234278", 12, 15, 64'd434234234278, 1'b0, 0, 1'b0);
    run_line("818181911112111", 12, 15, 64'd888911112111, 1'b0, 0, 1'b0);
    check("total_k12", total, 64'd3121910778619);

    run_line("57", 3, 2, 64'd57, 1'b1, 0, 1'b0);
    run_line("57", 0, 2, 64'd0, 1'b1, 0, 1'b0);
    run_line("9", 12, 3, 64'd9, 1'b1, 0, 1'b0);

    @(negedge clock);
    clear_total = 1'b1;
    @(negedge clock);
    clear_total = 1'b0;
    model_total = 64'd0;
    run_line("300", 3, 3, 64'd300, 1'b0, 0, 1'b0);
    check("total_300", total, 64'd300);
    run_line("987654321111111", 2, 15, 64'd98, 1'b0, 0, 1'b1);
    check("clear_on_handshake", total, 64'd98);

    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_digit = 4'(9 - i); in_last = 1'b0; k = 5'd2; line_len = 8'd15;
      @(negedge clock);
    end
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_total = 64'd0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (res_valid) check("no_result_after_reset", res_valid, 0);
    end
    check("mid_reset_total", total, 0);
    run_line("987654321111111", 2, 15, 64'd98, 1'b0, 0, 1'b0);
    check("post_reset_total", total, 64'd98);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/digit_subseq_maxer.md
Name: digit_subseq_maxer

Overview:
- Streaming successor to the single-line long-pop digit stack.
- Accepts decimal digits over a valid/ready stream, one line at a time. Keeps the lexicographically largest length-k subsequence of each line, with k selectable at runtime up to MAX_K.
- At end of line, converts the kept digits to a binary value, presents it on a result handshake, and adds it to a running total.
- Sits between the input parser and the answer-reporting logic.

Parameters:
- MAX_K, 12, stack depth and the largest legal k.
- DIGIT_W, 4, width of one digit (values 0-9).
- LEN_W, 8, width of the line-length and index counters.
- RES_W, 64, width of the per-line result.
- SUM_W, 64, width of the running total.

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- k  in  $clog2(MAX_K)+1  digits to keep; sampled on the first beat of each line.
- line_len  in  LEN_W  total digits in the line; sampled on the first beat.
- in_valid  in  1  digit beat valid.
- in_ready  out  1  block can accept a beat.
- in_digit  in  DIGIT_W  digit value.
- in_last  in  1  final digit of the line.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumed.
- res_value  out  RES_W  decimal value of the kept digits.
- res_err  out  1  line malformed (see Behaviour).
- clear_total  in  1  zero the running total.
- total  out  SUM_W  sum of all accepted results.

Behaviour:
- FSM states and transitions:
  - ACCUM: in_ready=1.
  - ACCUM -> CONVERT on an accepted beat with in_last=1.
  - CONVERT -> OUTPUT after sp cycles; if sp=0, after 0 extra cycles.
  - OUTPUT -> ACCUM on res_valid && res_ready.
- in_ready=0 in CONVERT and OUTPUT.
- Reset values: state=ACCUM, sp=0, idx=0, all stack entries=0, res_valid=0, res_value=0, res_err=0, total=0.
- Beat index and remaining count:
  - idx counts accepted beats within the line, starting at 0.
  - rem = len_q - idx, where len_q is line_len sampled when idx=0. rem includes the current digit.
- Per-beat insert, single cycle:
  - lo = max(0, k_q - rem).
  - p = smallest i in [lo, sp] such that data[j] < in_digit for every j in [i, sp).
  - If p < k_q: write data[p] = in_digit and set sp = p+1.
  - Otherwise: discard the digit and leave sp unchanged.
  - Equal digits never pop (strict <).
- CONVERT: acc = acc*10 + data[i] for i = 0..sp-1, one digit per cycle, truncated to RES_W.
- res_value and res_valid are registered. Both are held stable in OUTPUT until the handshake.
- On the handshake:
  - total += res_value, wrapping modulo 2^SUM_W.
  - sp, idx and acc clear for the next line.
- res_err is set when any of these hold:
  - k_q = 0 or k_q > MAX_K (result forced to 0, digits ignored);
  - line_len < k_q, or in_last arrives at idx != len_q-1 (result uses the digits present);
  - any in_digit > 9 (that digit treated as 0).
- A beat at idx = len_q-1 without in_last: treat as last and set res_err.
- clear_total:
  - Zeros total the next cycle.
  - If asserted in the same cycle as a result handshake, total = res_value.
- Reset mid-line or mid-output: all state returns to its reset value. The partial line is lost and no result is emitted.
- Latency from the last beat accepted to res_valid: sp+1 cycles.

Test Plan:
- k=2, lines 987654321111111, 811111111111119, 234234234234278, 818181911112111 -> res_value 98, 89, 78, 92; total 357.
- k=12, same four lines -> 987654321111, 811111111119, 434234234278, 888911112111; total 3121910778619.
- res_ready held low 10 cycles in OUTPUT -> res_value stable, in_ready=0, total unchanged until the handshake.
- k=3, line_len=2, line 57 -> res_value 57, res_err=1; k=0 -> res_value 0, res_err=1.
- clear_total pulsed in the same cycle as the handshake of res_value 98 with total=300 -> total=98 the next cycle.
- Reset asserted after 5 beats of a 15-digit line -> res_valid never rises; the next full line 987654321111111 with k=2 yields 98 and total=98.
